// File: rtl/clmod_pkg.sv
// clmod_pkg: shared state encoding and step-count helpers for the carry-less reducer.
package clmod_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int nsteps(input int width, input int step);
        return (width + step - 1) / step;
    endfunction

    function automatic int cnt_w(input int width, input int step);
        return $clog2(nsteps(width, step) + 1);
    endfunction

endpackage

// File: rtl/clmod_step.sv
// clmod_step: combinational slice clearing STEP dividend positions, highest first.
module clmod_step #(
    parameter int WIDTH = 409,
    parameter int STEP  = 32,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic [2*WIDTH-1:0] r,
    input  logic [WIDTH:0]     m,
    input  logic [PW-1:0]      top,
    input  logic               q_en,
    output logic [2*WIDTH-1:0] r_next,
    output logic [WIDTH-1:0]   q
);
    logic [2*WIDTH-1:0] mx;

    assign mx = {{(WIDTH - 1){1'b0}}, m};

    // Positions below WIDTH belong to the remainder and are left untouched.
    always_comb begin
        r_next = r;
        q      = '0;
        for (int j = 0; j < STEP; j++) begin
            int k;
            k = int'(top) - j;
            if (k >= WIDTH) begin
                if (r_next[k]) begin
                    r_next = r_next ^ (mx << (k - WIDTH));
                    if (q_en) q[k-WIDTH] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clmod.sv
// clmod: multi-cycle GF(2)[x] reducer, dividend mod (x^WIDTH + mod_i), STEP positions per cycle.
// Optional quotient register built when CLMOD_QUOTIENT_EN is defined.
module clmod
    import clmod_pkg::*;
#(
    parameter int WIDTH = 409,
    parameter int STEP  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic [2*WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]   mod_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               done_p_o,
    output logic [WIDTH-1:0]   remainder_o,
    output logic [WIDTH-1:0]   quotient_o
);
    localparam int NSTEP = nsteps(WIDTH, STEP);
    localparam int CW    = cnt_w(WIDTH, STEP);
    localparam int PW    = $clog2(2 * WIDTH);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] r_q, r_step;
    logic [WIDTH:0]     m_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      top;
    logic [WIDTH-1:0]   q_step;
    logic               done_p_q, last, load;

    assign last = cnt_q == CW'(NSTEP - 1);
    assign load = start_i && state_q != RUN;
    assign top  = PW'(2 * WIDTH - 1 - int'(cnt_q) * STEP);

`ifdef CLMOD_QUOTIENT_EN
    localparam logic QEN = 1'b1;
    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= '0;
        else if (flush_i || load) q_q <= '0;
        else if (state_q == RUN) q_q <= q_q | q_step;

    assign quotient_o = q_q;
`else
    localparam logic QEN = 1'b0;
    logic unused_q;

    assign unused_q   = ^q_step;
    assign quotient_o = '0;
`endif

    clmod_step #(.WIDTH(WIDTH), .STEP(STEP), .PW(PW)) u_step (
        .r      (r_q),
        .m      (m_q),
        .top    (top),
        .q_en   (QEN),
        .r_next (r_step),
        .q      (q_step)
    );

    // Flush beats start; start is ignored while a reduction is running.
    always_comb begin
        state_d = state_q;
        if (flush_i) state_d = IDLE;
        else if (state_q == RUN) state_d = last ? DONE : RUN;
        else if (start_i) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            r_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            done_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_p_q <= 1'b0;
            if (flush_i) begin
                r_q   <= '0;
                m_q   <= '0;
                cnt_q <= '0;
            end else if (load) begin
                r_q   <= dividend_i;
                m_q   <= {1'b1, mod_i};
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                r_q      <= r_step;
                cnt_q    <= cnt_q + 1'b1;
                done_p_q <= last;
            end
        end
    end

    assign busy_o      = state_q == RUN;
    assign done_o      = state_q == DONE;
    assign done_p_o    = done_p_q;
    assign remainder_o = r_q[WIDTH-1:0];

endmodule

// File: tb/tb_clmod.sv
// tb_clmod: scoreboard bench for clmod, small (8/4) and default (409/32) instances.
module tb_clmod;
    localparam int BW = 409;

`ifdef CLMOD_QUOTIENT_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        s_start = 1'b0, s_flush = 1'b0;
    logic [15:0] s_div = '0;
    logic [7:0]  s_mod = '0;
    logic        s_busy, s_done, s_done_p;
    logic [7:0]  s_rem, s_quo;

    logic            b_start = 1'b0, b_flush = 1'b0;
    logic [2*BW-1:0] b_div = '0;
    logic [BW-1:0]   b_mod = '0;
    logic            b_busy, b_done, b_done_p;
    logic [BW-1:0]   b_rem, b_quo;

    int n_chk = 0, n_pass = 0;
    int s_pulses = 0, b_pulses = 0;
    logic [15:0]       sq[$];
    logic [2*BW-1:0]   bq[$];

    always #5 clk = ~clk;

    clmod #(.WIDTH(8), .STEP(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .flush_i(s_flush),
        .dividend_i(s_div), .mod_i(s_mod), .busy_o(s_busy), .done_o(s_done),
        .done_p_o(s_done_p), .remainder_o(s_rem), .quotient_o(s_quo)
    );

    clmod u_big (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .flush_i(b_flush),
        .dividend_i(b_div), .mod_i(b_mod), .busy_o(b_busy), .done_o(b_done),
        .done_p_o(b_done_p), .remainder_o(b_rem), .quotient_o(b_quo)
    );

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitors: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (s_done_p) begin
            s_pulses++;
            if (sq.size() == 0) begin
                n_chk++;
                $display("FAIL s_unexpected_done: got rem %0h quo %0h expected no result", s_rem, s_quo);
            end else check("s_result", {s_rem, s_quo}, sq.pop_front());
        end
        if (b_done_p) begin
            b_pulses++;
            if (bq.size() == 0) begin
                n_chk++;
                $display("FAIL b_unexpected_done: got rem %0h expected no result", b_rem);
            end else check("b_result", {b_rem, b_quo}, bq.pop_front());
        end
    end

    task automatic s_go(input logic [15:0] div, input logic [7:0] er, input logic [7:0] eq, input bit exp_res);
        s_start = 1'b1;
        s_div   = div;
        s_mod   = 8'h1B;
        if (exp_res) sq.push_back({er, QEN ? eq : 8'h00});
        @(negedge clk);
        s_start = 1'b0;
    endtask

    task automatic s_wait_done(input string name);
        int n = 0;
        while (!s_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, s_done, 1);
    endtask

    initial begin
        logic [BW-1:0] b_exp_rem, b_exp_quo;
        int n, n_busy;
        repeat (2) @(negedge clk);
        check("rst_s_busy", s_busy, 0);
        check("rst_s_done", s_done, 0);
        check("rst_s_done_p", s_done_p, 0);
        check("rst_s_out", {s_rem, s_quo}, 0);
        check("rst_b_out", {b_busy, b_done, b_done_p, b_rem, b_quo}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        s_go(16'h2B79, 8'hC1, 8'h28, 1'b1);
        check("s1_busy_e0", {s_busy, s_done}, 2'b10);
        @(negedge clk);
        check("s1_busy_e1", {s_busy, s_done}, 2'b10);
        @(negedge clk);
        check("s1_done_e2", {s_busy, s_done, s_done_p}, 3'b011);
        check("s1_rem_e2", s_rem, 8'hC1);
        @(negedge clk);
        check("s1_hold_e3", {s_done, s_done_p}, 2'b10);
        check("s1_rem_hold", s_rem, 8'hC1);

        s_go(16'h2B79, 8'hC1, 8'h28, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("b2b_first_done", s_done, 1);
        s_go(16'h00A5, 8'hA5, 8'h00, 1'b1);
        check("b2b_done_drop", {s_busy, s_done}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        check("b2b_second_done", {s_done, s_done_p}, 2'b11);
        check("b2b_rem", s_rem, 8'hA5);

        s_go(16'h011B, 8'h00, 8'h01, 1'b1);
        s_wait_done("s_011b_done");
        s_go(16'h00A5, 8'hA5, 8'h00, 1'b1);
        s_wait_done("s_00a5_done");

        s_go(16'h2B79, 8'h00, 8'h00, 1'b0);
        s_flush = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_flush = 1'b0;
        s_start = 1'b0;
        check("flush_state", {s_busy, s_done, s_done_p}, 0);
        check("flush_out", {s_rem, s_quo}, 0);
        repeat (4) @(negedge clk);
        check("flush_no_done", s_done, 0);

        b_exp_rem = '0;
        b_exp_rem[87] = 1'b1;
        b_exp_rem[0] = 1'b1;
        b_exp_quo = QEN ? BW'(1) : '0;
        b_start = 1'b1;
        b_div = '0;
        b_div[BW] = 1'b1;
        b_mod = b_exp_rem;
        bq.push_back({b_exp_rem, b_exp_quo});
        @(negedge clk);
        b_start = 1'b0;
        n = 0;
        n_busy = 0;
        while (!b_done && n < 40) begin
            if (b_busy) n_busy++;
            @(negedge clk);
            n++;
        end
        check("b_done_edge", n, 13);
        check("b_busy_cycles", n_busy, 13);
        check("b_rem_level", b_rem, b_exp_rem);

        s_go(16'h2B79, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_state", {s_busy, s_done, s_done_p}, 0);
        check("rst_mid_out", {s_rem, s_quo}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid_no_done", s_done, 0);

        check("s_pulse_count", s_pulses, 5);
        check("b_pulse_count", b_pulses, 1);
        check("s_queue_empty", sq.size(), 0);
        check("b_queue_empty", bq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clmod.md
# clmod

Multi-cycle carry-less polynomial reducer over GF(2)[x]: divides a 2·WIDTH-bit carry-less product by a monic degree-WIDTH modulus and returns remainder (and optionally quotient). It is the consumer-side complement of the partitioned carry-less multiplier in the EXU custom datapath. It clears STEP dividend bit positions per cycle, so a full binary-field multiply is multiplier followed by clmod.

## Interface
- WIDTH, 409, field degree; modulus is x^WIDTH + mod_i.
- STEP, 32, dividend bit positions cleared per cycle (1..WIDTH).
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  capture dividend_i/mod_i and begin reduction
- flush_i  in  1  synchronous abort to IDLE
- dividend_i  in  2*WIDTH  dividend (carry-less product)
- mod_i  in  WIDTH  low coefficients of modulus; bit WIDTH implicitly 1
- busy_o  out  1  reduction in progress
- done_o  out  1  result valid, level, held until next start/flush
- done_p_o  out  1  one-cycle pulse on done_o rising
- remainder_o  out  WIDTH  dividend mod modulus
- quotient_o  out  WIDTH  dividend div modulus

## Operation
- NSTEP = ceil(WIDTH/STEP); step counter width $clog2(NSTEP+1).
- States: IDLE, RUN, DONE.
- IDLE/DONE + start_i: R <= dividend_i, M <= {1'b1, mod_i}, Q <= 0, cnt <= 0, -> RUN, done_o <= 0.
- RUN, each cycle: for positions k = 2W-1-cnt·STEP down to k-STEP+1, in descending order within the cycle: if k >= WIDTH and R[k]: R ^= M << (k-WIDTH), Q[k-WIDTH] <= 1. Positions < WIDTH in the last step are masked (no-op). cnt++.
- RUN with cnt == NSTEP-1 completing: -> DONE, done_o <= 1.
- DONE: remainder_o = R[WIDTH-1:0], quotient_o = Q, held stable.
- start_i in RUN ignored; operands not re-sampled.
- flush_i (any state) -> IDLE, done_o <= 0, R/Q/cnt cleared; flush_i wins over start_i on the same edge.
- Top dividend bit 2W-1 is handled normally (quotient bit W-1).
- Dividend with R[2W-1:W] == 0 still takes NSTEP cycles; remainder = dividend_i[W-1:0], quotient 0.
- mod_i bits are used as given; no irreducibility check.

## Timing
- Reset: state IDLE, busy_o 0, done_o 0, done_p_o 0, remainder_o 0, quotient_o 0, internal R/M/Q/cnt 0.
- Edge 0 samples start_i; busy_o high from edge 0 to edge NSTEP.
- done_o rises at edge NSTEP after the start edge; done_p_o high exactly the cycle after that edge.
- Back-to-back: start_i in the first DONE cycle is accepted; done_o falls on that edge; the pulse rule repeats.
- remainder_o/quotient_o are undefined-but-stable (internal R/Q) while busy; consumers use them only when done_o.
- Reset mid-RUN: immediate IDLE, all outputs 0.
- Critical path: STEP serial conditional XORs of WIDTH+1 bits.

## Configuration
- CLMOD_QUOTIENT_EN defined: Q register is built and quotient_o carries the quotient.
- Undefined: no Q register; quotient_o tied to 0; remainder and timing are unchanged.

## Structure
- clmod_pkg: state enum (IDLE/RUN/DONE), function nsteps(WIDTH, STEP), function cnt_w.
- Sub-module clmod_step: combinational STEP-position reduction slice. Inputs are R, M, the top position and the quotient-bit enable; outputs are the next R and the quotient bits for that slice. It is instantiated once in clmod.

## Test plan
- WIDTH=8, STEP=4, mod_i=0x1B, dividend 0x2B79 (0x57 clmul 0x83) -> remainder 0xC1, quotient 0x28; done_o at edge 2, done_p_o one cycle.
- WIDTH=8, STEP=4, mod 0x1B, dividend 0x011B -> remainder 0x00, quotient 0x01; dividend 0x00A5 -> remainder 0xA5, quotient 0x00.
- Default params, mod_i = (1<<87)|1, dividend = 1<<409 -> remainder (1<<87)|1, quotient 1; busy_o 13 cycles, done at edge 13.
- Flush at edge 1 of RUN with start_i also high -> IDLE; done_o never asserts; outputs 0.
- start_i in DONE with 0x2B79 then 0x00A5 -> done_o drops, second result 0xA5 after 2 edges, second done_p_o.
- Build without CLMOD_QUOTIENT_EN, first scenario -> remainder 0xC1, quotient_o 0.
